// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, default depth and command record for the data memory arbiter
package dmem_pkg;
    localparam int DMEM_DEPTH_LOG2 = 4;
    localparam int CMD_AW = 16;
    localparam int CMD_DW = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    typedef struct packed {
        logic              we;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
        logic              port;
    } cmd_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker
// ports: req[1:0] requests, last = previous winner, gnt one-hot grant, valid = any request
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);
    always_comb begin
        valid = |req;
        gnt   = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin serialiser of two req/ack ports onto the single-port data memory
// ports: clk, rst_n (sync, active low); req/we/addr0/addr1/wdata0/wdata1 from requesters;
//        ack/err/rdata/busy back to requesters; mem_addr/mem_wdata/mem_we/mem_re/mem_rdata to memory
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = CMD_AW,
    parameter int DW         = CMD_DW,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    ack,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);
    state_t     state;
    cmd_t       cmd;
    logic       last;
    logic       err_q;
    logic [1:0] gnt;
    logic       valid;
    logic       pick;
    logic       in_range;
    logic       in_access;

    rr_pick2 u_pick (.req(req), .last(last), .gnt(gnt), .valid(valid));

    always_comb begin
        pick      = gnt[1] & ~gnt[0];
        in_range  = (cmd.addr >> DEPTH_LOG2) == '0;
        in_access = state == ACCESS;
        mem_addr  = in_access ? cmd.addr : '0;
        mem_wdata = in_access ? cmd.wdata : '0;
        // gated by rst_n so a reset landing on ACCESS cannot commit the write
        mem_we    = rst_n & in_access & in_range & cmd.we;
        mem_re    = rst_n & in_access & in_range & ~cmd.we;
        ack       = (state == DONE) ? (cmd.port ? 2'b10 : 2'b01) : 2'b00;
        err       = (state == DONE) & err_q;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cmd   <= '0;
            last  <= 1'b1;
            err_q <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    cmd   <= '{we: we[pick], addr: pick ? addr1 : addr0,
                               wdata: pick ? wdata1 : wdata0, port: pick};
                    last  <= pick;
                    state <= ACCESS;
                end
                ACCESS: begin
                    err_q <= ~in_range;
                    if (!in_range) rdata <= '0;
                    else if (!cmd.we) rdata <= mem_rdata;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
